alu_operand_b_select: RTL and testbench

- ALU operand-B select stage of the pipelined processor.
- Chooses between the immediate value from the immediate buffer and the register/forwarded value from mux m3, then registers the result for the ALU.
- `cntrl_m7=1` selects the immediate; `cntrl_m7=0` selects the m3 value.
- Includes an immediate-extension unit and a stall/flush-capable pipeline register.

---
 rtl/alu_operand_b_select.sv | 88 ++++++++
 tb/tb_alu_operand_b_select.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/alu_operand_b_select.sv
// alu_operand_b_select
//   Operand-B select stage ahead of the ALU. The stage extends the immediate
//   from the immediate buffer and selects either that value or the
//   register/forwarded value from mux m3. It registers the selected value
//   for the ALU in a pipeline register that can be stalled or flushed.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   cntrl_m7    1 = extended immediate, 0 = in_m3
//   in_imm_buf  raw immediate word
//   ext_mode    00 full word, 01 sign-ext low SHORT_W, 10 zero-ext low SHORT_W,
//               11 low SHORT_W placed in the upper bits (upper-immediate)
//   in_m3       register/forwarded operand
//   in_valid    upstream instruction valid
//   stall       hold the pipeline register
//   flush       squash the pipeline register (takes priority over stall)
//   sel_comb    combinational selected operand (same-cycle bypass)
//   out_alu     registered operand B
//   out_valid   out_alu carries a valid operand
module alu_operand_b_select #(
  parameter int DATA_W  = 16,
  parameter int SHORT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cntrl_m7,
  input  logic [DATA_W-1:0] in_imm_buf,
  input  logic [1:0]        ext_mode,
  input  logic [DATA_W-1:0] in_m3,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  output logic [DATA_W-1:0] sel_comb,
  output logic [DATA_W-1:0] out_alu,
  output logic              out_valid
);

  localparam int UPPER_W = DATA_W - SHORT_W;

  logic [SHORT_W-1:0] imm_short;
  logic [DATA_W-1:0]  imm_x;
  logic [DATA_W-1:0]  out_alu_d, out_alu_q;
  logic               out_valid_d, out_valid_q;

  assign imm_short = in_imm_buf[SHORT_W-1:0];

  always_comb begin
    imm_x = in_imm_buf;
    case (ext_mode)
      2'b00: imm_x = in_imm_buf;
      2'b01: imm_x = {{UPPER_W{imm_short[SHORT_W-1]}}, imm_short};
      2'b10: imm_x = {{UPPER_W{1'b0}}, imm_short};
      2'b11: imm_x = {imm_short, {UPPER_W{1'b0}}};
      default: imm_x = in_imm_buf;
    endcase
  end

  assign sel_comb = cntrl_m7 ? imm_x : in_m3;

  // Flush beats stall so a squashed slot never survives a concurrent hold.
  // out_alu loads even for invalid slots; consumers qualify with out_valid.
  always_comb begin
    out_alu_d   = out_alu_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_alu_d   = '0;
      out_valid_d = 1'b0;
    end else if (!stall) begin
      out_alu_d   = sel_comb;
      out_valid_d = in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_alu_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_alu_q   <= out_alu_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_alu   = out_alu_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_operand_b_select.sv
module tb_alu_operand_b_select;

  logic        clk = 1'b0;
  logic        rst;
  logic        cntrl_m7;
  logic [15:0] in_imm_buf;
  logic [1:0]  ext_mode;
  logic [15:0] in_m3;
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic [15:0] sel_comb;
  logic [15:0] out_alu;
  logic        out_valid;

  int n_tests = 0;
  int n_fail  = 0;

  // reference pipeline register contents
  int exp_out;
  int exp_valid;

  always #5 clk = ~clk;

  alu_operand_b_select #(.DATA_W(16), .SHORT_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cntrl_m7   (cntrl_m7),
    .in_imm_buf (in_imm_buf),
    .ext_mode   (ext_mode),
    .in_m3      (in_m3),
    .in_valid   (in_valid),
    .stall      (stall),
    .flush      (flush),
    .sel_comb   (sel_comb),
    .out_alu    (out_alu),
    .out_valid  (out_valid)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_ext(input int mode, input int imm);
    int low;
    low = imm % 256;
    case (mode)
      0: return imm;
      1: return (low >= 128) ? (low + 65536 - 256) : low;
      2: return low;
      default: return low * 256;
    endcase
  endfunction

  function automatic int ref_sel(input int m7, input int mode, input int imm, input int m3);
    return m7 ? ref_ext(mode, imm) : m3;
  endfunction

  // One full cycle: drive at negedge, check bypass path, clock, check register.
  task automatic cycle(input logic r, input logic m7, input logic [15:0] imm,
                       input logic [1:0] mode, input logic [15:0] m3,
                       input logic v, input logic st, input logic fl);
    int es;
    rst = r; cntrl_m7 = m7; in_imm_buf = imm; ext_mode = mode;
    in_m3 = m3; in_valid = v; stall = st; flush = fl;
    es = ref_sel(int'(m7), int'(mode), int'(imm), int'(m3));
    #1;
    check("sel_comb", int'(sel_comb), es);
    @(posedge clk);
    if (r || fl) begin
      exp_out = 0; exp_valid = 0;
    end else if (!st) begin
      exp_out = es; exp_valid = int'(v);
    end
    @(negedge clk);
    check("out_alu", int'(out_alu), exp_out);
    check("out_valid", int'(out_valid), exp_valid);
  endtask

  initial begin
    exp_out = 0; exp_valid = 0;
    // reset two cycles
    cycle(1, 0, 16'h0000, 2'b00, 16'h0000, 0, 0, 0);
    cycle(1, 0, 16'h0000, 2'b00, 16'h0000, 0, 0, 0);
    check("rst_out_alu", int'(out_alu), 0);
    check("rst_out_valid", int'(out_valid), 0);

    cycle(0, 1, 16'h20F0, 2'b00, 16'h00FF, 1, 0, 0);
    check("imm_full", int'(out_alu), 16'h20F0);
    check("imm_full_valid", int'(out_valid), 1);
    cycle(0, 0, 16'h8888, 2'b00, 16'h5555, 1, 0, 0);
    check("m3_sel", int'(out_alu), 16'h5555);
    cycle(0, 1, 16'h1550, 2'b00, 16'h1F00, 1, 0, 0);
    check("imm_1550", int'(out_alu), 16'h1550);
    cycle(0, 1, 16'h0088, 2'b01, 16'h1F00, 1, 0, 0);
    check("ext_sign", int'(out_alu), 16'hFF88);
    cycle(0, 1, 16'h0088, 2'b10, 16'h1F00, 1, 0, 0);
    check("ext_zero", int'(out_alu), 16'h0088);
    cycle(0, 1, 16'h0088, 2'b11, 16'h1F00, 1, 0, 0);
    check("ext_upper", int'(out_alu), 16'h8800);

    // stall holds, release loads
    cycle(0, 1, 16'h20F0, 2'b00, 16'h0000, 1, 0, 0);
    cycle(0, 0, 16'h20F0, 2'b00, 16'h5555, 0, 1, 0);
    check("stall_hold", int'(out_alu), 16'h20F0);
    check("stall_hold_valid", int'(out_valid), 1);
    cycle(0, 0, 16'h20F0, 2'b00, 16'h5555, 1, 0, 0);
    check("stall_release", int'(out_alu), 16'h5555);

    // flush beats stall
    cycle(0, 0, 16'h0000, 2'b00, 16'hABCD, 1, 1, 1);
    check("flush_stall", int'(out_alu), 0);
    check("flush_stall_valid", int'(out_valid), 0);

    // reset during stall discards held value
    cycle(0, 0, 16'h0000, 2'b00, 16'h1234, 1, 0, 0);
    cycle(0, 0, 16'h0000, 2'b00, 16'h9999, 1, 1, 0);
    check("pre_rst_hold", int'(out_alu), 16'h1234);
    cycle(1, 0, 16'h0000, 2'b00, 16'h9999, 1, 1, 0);
    check("rst_in_stall", int'(out_alu), 0);
    check("rst_in_stall_valid", int'(out_valid), 0);

    // randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      cycle(($urandom % 32) == 0,
            1'($urandom),
            16'($urandom),
            2'($urandom),
            16'($urandom),
            1'($urandom),
            ($urandom % 5) == 0,
            ($urandom % 16) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
